// File: rtl/bist_scan_controller_if.sv
// bist_scan_controller_if: session request, MISR signature and BIST control/status bundle
//   master: drives start/misr_sig, observes controls and status
//   slave:  the controller; samples start/misr_sig, drives everything else
interface bist_scan_controller_if #(
    parameter int SIG_WIDTH = 7,
    parameter int CNT_WIDTH = 5
);
    logic                 start;
    logic [SIG_WIDTH-1:0] misr_sig;
    logic                 lfsr_reset;
    logic                 lfsr_enable;
    logic                 scan_enable;
    logic                 capture;
    logic                 misr_clear;
    logic                 misr_enable;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_WIDTH-1:0] pattern_count;
    modport master (
        output start, misr_sig,
        input  lfsr_reset, lfsr_enable, scan_enable, capture, misr_clear, misr_enable,
        input  busy, done, pass, pattern_count
    );
    modport slave (
        input  start, misr_sig,
        output lfsr_reset, lfsr_enable, scan_enable, capture, misr_clear, misr_enable,
        output busy, done, pass, pattern_count
    );
endinterface

// File: rtl/bist_scan_controller.sv
// bist_scan_controller: sequences one scan BIST session (LFSR, shift, capture, MISR, compare)
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/misr_sig in; LFSR/scan/MISR controls, busy/done/pass, pattern_count out
module bist_scan_controller #(
    parameter int                   CHAIN_LEN    = 8,
    parameter int                   NUM_PATTERNS = 16,
    parameter int                   SIG_WIDTH    = 7,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 7'h35
) (
    input logic clock,
    input logic reset,
    bist_scan_controller_if.slave bus
);
    localparam int BW = $clog2(CHAIN_LEN);
    localparam int CW = $clog2(NUM_PATTERNS + 1);
    typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE} state_t;
    state_t          state, nxt;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic [CW-1:0]   cnt_inc, cnt_nxt;
    logic            last, pass_nxt;
    assign cnt_inc = bus.pattern_count + CW'(1);
    assign last    = bit_cnt == BW'(CHAIN_LEN - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = bus.start ? INIT : state;
            INIT:       nxt = SHIFT;
            SHIFT:      nxt = last ? CAPTURE : SHIFT;
            CAPTURE:    nxt = cnt_inc == CW'(NUM_PATTERNS) ? FLUSH : SHIFT;
            FLUSH:      nxt = last ? COMPARE : FLUSH;
            COMPARE:    nxt = DONE;
            default:    nxt = IDLE;
        endcase
        bit_nxt  = nxt == state && (state == SHIFT || state == FLUSH) ? bit_cnt + BW'(1) : '0;
        cnt_nxt  = nxt == INIT ? '0 : state == CAPTURE ? cnt_inc : bus.pattern_count;
        pass_nxt = nxt == INIT ? 1'b0 : state == COMPARE ? bus.misr_sig == GOLDEN_SIG : bus.pass;
    end
    // Outputs are decoded from the next state and registered, so they line up with state
    // and never see a combinational path from start or misr_sig.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            bus.pattern_count <= '0;
            bus.pass          <= 1'b0;
            bus.lfsr_reset    <= 1'b0;
            bus.lfsr_enable   <= 1'b0;
            bus.scan_enable   <= 1'b0;
            bus.capture       <= 1'b0;
            bus.misr_clear    <= 1'b0;
            bus.misr_enable   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            state             <= nxt;
            bit_cnt           <= bit_nxt;
            bus.pattern_count <= cnt_nxt;
            bus.pass          <= pass_nxt;
            bus.lfsr_reset    <= nxt == INIT;
            bus.misr_clear    <= nxt == INIT;
            bus.lfsr_enable   <= nxt == SHIFT;
            bus.scan_enable   <= nxt == SHIFT || nxt == FLUSH;
            bus.capture       <= nxt == CAPTURE;
            // chain holds unknown data until the first capture, so pattern 0's shift is not compacted
            bus.misr_enable   <= (nxt == SHIFT && cnt_nxt != '0) || nxt == FLUSH;
            bus.busy          <= nxt != IDLE && nxt != DONE;
            bus.done          <= nxt == DONE;
        end
    end
endmodule
